// File: rtl/dbus_pkg.sv
// Shared types for the core data-bus bridge: FSM states, the registered bus
// request, and the word returned when a slave never answers.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;

  // Word-aligns the address and forces byte enables off for loads.
  function automatic bus_req_t make_req(input logic        store,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  wmask);
    bus_req_t r;
    r.addr  = {addr[31:2], 2'b00};
    r.we    = store;
    r.wdata = wdata;
    r.wmask = store ? wmask : 4'b0000;
    return r;
  endfunction

endpackage

// File: rtl/dbus_timeout.sv
// Wait-state counter for one bus access; o_expired flags the last cycle the
// bridge may wait for bus_ready before aborting.
module dbus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/dbus_bridge.sv
// Runs one captured core load/store over a valid/ready data bus, stalling the
// core until the slave answers or the wait-state budget runs out.
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  state_t      r_state;
  state_t      w_state_next;
  bus_req_t    r_req;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_accept;
  logic        w_handshake;
  logic        w_timeout;
  logic        w_expired;
  logic        w_busy;

  assign w_busy = (r_state == BUSY);

  dbus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (w_busy),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        // A ready arriving on the expiry cycle still completes normally.
        if (bus_ready) begin
          w_handshake  = 1'b1;
          w_state_next = DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the payload registers are reset as well, so the bus and read-data
  // outputs show zero rather than stale contents right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_accept) begin
        r_req <= make_req(req_store, req_addr, req_wdata, req_wmask);
      end
      if (w_handshake) begin
        r_rdata <= r_req.we ? 32'h0 : bus_rdata;
      end else if (w_timeout) begin
        r_rdata <= ERR_DATA;
      end
    end
  end

  assign bus_valid   = w_busy;
  assign bus_we      = r_req.we;
  assign bus_addr    = r_req.addr;
  assign bus_wdata   = r_req.wdata;
  assign bus_wmask   = r_req.wmask;
  assign rdata       = r_rdata;
  assign err         = r_err;
  assign rdata_valid = (r_state == DONE);
  assign stall       = ((r_state == IDLE) && req_valid) || w_busy;

endmodule
